seq_tx: RTL

SEQ_TX -- requirements
Module: seq_tx

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_tx.sv | 114 +++++++++++
 2 files changed

// File: rtl/seq_pkg.sv
// Shared constants for the sync-word transmitter and the matching 1101 detector.
// Gray-coded state values keep single-bit transitions around the frame loop.
package seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SYNC = 2'b01,
      ST_DATA = 2'b11,
      ST_GAP  = 2'b10
   } seq_state_e;

   localparam int         SYNC_W_DEF = 4;
   localparam logic [3:0] SYNC_DEF   = 4'b1101;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seq_tx.sv
// Framed serial transmitter: sync word then payload, MSB first, one bit per clock,
// followed by a single gap cycle that pulses done.
//
// state | meaning
// IDLE  | waiting for a payload handshake; in_ready high
// SYNC  | shifting out the sync word, cnt indexes the bit
// DATA  | shifting out the captured payload from the shift register MSB
// GAP   | one idle cycle after the frame; done pulses
module seq_tx
   import seq_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter int                SYNC_W = SYNC_W_DEF,
   parameter logic [SYNC_W-1:0] SYNC   = SYNC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out,
   output logic              out_valid,
   output logic              done
);

   localparam int CNT_MAX = max_int(SYNC_W, DATA_W);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   seq_state_e        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [DATA_W-1:0] sh, sh_nxt;
   logic              rdy;
   logic              sync_bit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         sh    <= '0;
         rdy   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         sh    <= sh_nxt;
         // Registered so in_ready stays low throughout reset and rises on the first edge after it.
         rdy   <= (state_nxt == ST_IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sh_nxt    = sh;
      case (state)
         ST_IDLE: begin
            if (in_valid && rdy) begin
               sh_nxt    = in_data;
               cnt_nxt   = '0;
               state_nxt = ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (cnt == SYNC_LAST) begin
               cnt_nxt   = '0;
               state_nxt = ST_DATA;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_DATA: begin
            sh_nxt = sh << 1;
            if (cnt == DATA_LAST) begin
               cnt_nxt   = '0;
               state_nxt = ST_GAP;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_GAP:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      sync_bit = 1'b0;
      for (int i = 0; i < SYNC_W; i++) begin
         if (cnt == CNT_W'(SYNC_W - 1 - i)) sync_bit = SYNC[i];
      end
   end

   always_comb begin
      out       = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      case (state)
         ST_SYNC: begin
            out       = sync_bit;
            out_valid = 1'b1;
         end
         ST_DATA: begin
            out       = sh[DATA_W-1];
            out_valid = 1'b1;
         end
         ST_GAP:  done = 1'b1;
         default: ;
      endcase
   end

   assign in_ready = rdy;

endmodule
